// File: rtl/snake_head_stepper.sv
// Game-tick sequencer owning the snake head coordinates; borrows an external
// subtractor for left/up moves and handles right/down and all wrapping locally.
module snake_head_stepper #(
    parameter int COORD_W = 5,
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 32,
    parameter int START_X = 16,
    parameter int START_Y = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               pause,
    input  logic               dir_valid,
    input  logic [1:0]         dir_req,
    output logic [COORD_W-1:0] sub_a,
    output logic [COORD_W-1:0] sub_b,
    input  logic [COORD_W-1:0] sub_d,
    output logic [COORD_W-1:0] head_x,
    output logic [COORD_W-1:0] head_y,
    output logic [1:0]         dir_cur,
    output logic               head_valid,
    output logic               wrapped,
    output logic               tick_overrun
);

    typedef enum logic [1:0] {IDLE, CALC, COMMIT, PAUSED} state_t;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    localparam logic [COORD_W-1:0] MAX_X   = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] MAX_Y   = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] INIT_X  = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] INIT_Y  = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);
    localparam logic [COORD_W-1:0] ZERO    = '0;

    state_t             state, state_nxt;
    logic [1:0]         pending_dir;
    logic [COORD_W-1:0] next_x, next_y;
    logic               next_wrap;
    logic               step_start;
    logic               req_legal;

    assign step_start = (state == IDLE) && !pause && tick;
    // Opposite directions differ only in bit 0 of the encoding.
    assign req_legal  = dir_req != (dir_cur ^ 2'b01);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pause) state_nxt = PAUSED;
                     else if (tick) state_nxt = CALC;
            CALC:    state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            PAUSED:  if (!pause) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sub_a = ZERO;
        sub_b = ZERO;
        if (state == CALC) begin
            if (dir_cur == DIR_LEFT) begin
                sub_a = head_x;
                sub_b = ONE;
            end else if (dir_cur == DIR_UP) begin
                sub_a = head_y;
                sub_b = ONE;
            end
        end
    end

    always_comb begin
        next_x    = head_x;
        next_y    = head_y;
        next_wrap = 1'b0;
        case (dir_cur)
            DIR_RIGHT: begin
                next_wrap = (head_x == MAX_X);
                next_x    = next_wrap ? ZERO : head_x + ONE;
            end
            DIR_LEFT: begin
                next_wrap = (head_x == ZERO);
                next_x    = next_wrap ? MAX_X : sub_d;
            end
            DIR_UP: begin
                next_wrap = (head_y == ZERO);
                next_y    = next_wrap ? MAX_Y : sub_d;
            end
            DIR_DOWN: begin
                next_wrap = (head_y == MAX_Y);
                next_y    = next_wrap ? ZERO : head_y + ONE;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            head_x       <= INIT_X;
            head_y       <= INIT_Y;
            dir_cur      <= DIR_RIGHT;
            pending_dir  <= DIR_RIGHT;
            head_valid   <= 1'b0;
            wrapped      <= 1'b0;
            tick_overrun <= 1'b0;
        end else begin
            state      <= state_nxt;
            head_valid <= (state == CALC);
            wrapped    <= (state == CALC) && next_wrap;
            if (step_start)
                dir_cur <= pending_dir;
            if (dir_valid && req_legal)
                pending_dir <= dir_req;
            // Head registers update at the end of CALC so the new position and
            // the head_valid pulse both appear during COMMIT.
            if (state == CALC) begin
                head_x <= next_x;
                head_y <= next_y;
            end
            if (tick && (state == CALC || state == COMMIT))
                tick_overrun <= 1'b1;
        end
    end

endmodule
